raycast_arbiter: RTL and testbench

- Shares one `all_shapes_raycaster` instance between NUM_REQ requesters, e.g. primary camera rays, shadow/lighting rays and future reflection rays.
- Arbitrates round-robin, issues at most one request per cycle, and tracks in-flight requests with a tag FIFO.
- The raycaster returns results in issue order; each result is routed back to the requester that issued it.
- Sits between the `raytracing_controller` sub-units and the raycaster. Also supports a frame-abort flush.

---
 rtl/raycast_arbiter_pkg.sv | 32 +++
 rtl/raycast_arbiter_tag_fifo.sv | 45 ++++
 rtl/raycast_arbiter.sv | 169 ++++++++++++++++
 tb/tb_raycast_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/raycast_arbiter_pkg.sv
`default_nettype none
// raycast_arbiter_pkg: geometry types and request/result bundles shared by the raycast arbiter.
// Rev 1.0
package raycast_arbiter_pkg;

  typedef logic [15:0] float16;

  typedef struct packed {
    float16 x;
    float16 y;
    float16 z;
  } vec3;

  typedef logic [7:0] Shape;

  localparam int VEC3_W  = $bits(vec3);
  localparam int SHAPE_W = $bits(Shape);

  typedef struct packed {
    vec3 src;
    vec3 dir;
  } RaycastReq;

  typedef struct packed {
    logic hit;
    vec3  intersection;
    vec3  normal;
    Shape hit_shape;
  } RaycastResp;

endpackage
`default_nettype wire

// File: rtl/raycast_arbiter_tag_fifo.sv
`default_nettype none
// tag_fifo: synchronous FIFO of requester ids, one entry per ray in flight inside the raycaster.
// Rev 1.0
module tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clear) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/raycast_arbiter.sv
`default_nettype none
// raycast_arbiter: round-robin sharing of one raycaster among NUM_REQ requesters, in-order result routing, flush.
// Rev 1.0; define RAYCAST_ARB_STATS_EN to add grant_count / drop_count_total statistics outputs.
module raycast_arbiter
  import raycast_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*VEC3_W-1:0]     req_src,
  input  logic [NUM_REQ*VEC3_W-1:0]     req_dir,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic                          resp_hit,
  output logic [VEC3_W-1:0]             resp_intersection,
  output logic [VEC3_W-1:0]             resp_normal,
  output logic [SHAPE_W-1:0]            resp_shape,
  output logic                          rc_valid_in,
  output logic [VEC3_W-1:0]             rc_src,
  output logic [VEC3_W-1:0]             rc_dir,
  input  logic                          rc_valid_out,
  input  logic                          rc_hit,
  input  logic [VEC3_W-1:0]             rc_intersection,
  input  logic [VEC3_W-1:0]             rc_normal,
  input  logic [SHAPE_W-1:0]            rc_hit_shape,
`ifdef RAYCAST_ARB_STATS_EN
  output logic [NUM_REQ*32-1:0]         grant_count,
  output logic [31:0]                   drop_count_total,
`endif
  output logic [$clog2(MAX_OUTSTANDING):0] inflight
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  typedef logic [IDX_W-1:0] ReqId;

  ReqId             rr_ptr;
  ReqId             grant_idx;
  ReqId             issue_tag;
  ReqId             fifo_head;
  logic             grant_any;
  logic             credit_ok;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop_live;
  logic             drop_hit;
  logic [CNT_W:0]   occupancy;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] drop_sum;

  // A granted request not yet issued already owns a credit.
  assign occupancy = (CNT_W+1)'(inflight) + (CNT_W+1)'(drop_cnt) + (CNT_W+1)'(rc_valid_in);
  assign credit_ok = !rst && !flush && (occupancy < (CNT_W+1)'(MAX_OUTSTANDING));

  always_comb begin : p_grant
    int   idx;
    ReqId sel;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    sel       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = ReqId'(idx);
      if (credit_ok && !grant_any && req_valid[sel]) begin
        grant_any = 1'b1;
        grant_idx = sel;
      end
    end
  end

  assign req_ready = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;

  // Results owed to flushed requests are swallowed before any live tag is popped.
  assign pop_live = rc_valid_out && (drop_cnt == '0) && !fifo_empty;
  assign drop_hit = rc_valid_out && (drop_cnt != '0);
  assign drop_sum = drop_cnt - CNT_W'(drop_hit) + inflight + CNT_W'(rc_valid_in) - CNT_W'(pop_live);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr            <= '0;
      rc_valid_in       <= 1'b0;
      issue_tag         <= '0;
      rc_src            <= '0;
      rc_dir            <= '0;
      inflight          <= '0;
      drop_cnt          <= '0;
      resp_valid        <= '0;
      resp_hit          <= 1'b0;
      resp_intersection <= '0;
      resp_normal       <= '0;
      resp_shape        <= '0;
    end else begin
      rc_valid_in <= grant_any;
      if (grant_any) begin
        issue_tag <= grant_idx;
        rc_src    <= req_src[grant_idx*VEC3_W +: VEC3_W];
        rc_dir    <= req_dir[grant_idx*VEC3_W +: VEC3_W];
        rr_ptr    <= (grant_idx == ReqId'(NUM_REQ-1)) ? '0 : ReqId'(grant_idx + 1'b1);
      end
      resp_valid <= pop_live ? (NUM_REQ'(1) << fifo_head) : '0;
      if (pop_live) begin
        resp_hit          <= rc_hit;
        resp_intersection <= rc_intersection;
        resp_normal       <= rc_normal;
        resp_shape        <= rc_hit_shape;
      end
      if (flush) begin
        drop_cnt <= drop_sum;
        inflight <= '0;
      end else begin
        drop_cnt <= drop_cnt - CNT_W'(drop_hit);
        inflight <= inflight + CNT_W'(rc_valid_in) - CNT_W'(pop_live);
      end
    end
  end

  tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (IDX_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (rc_valid_in),
    .din   (issue_tag),
    .pop   (pop_live),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

`ifdef RAYCAST_ARB_STATS_EN
  logic [31:0] grant_cnt_q [NUM_REQ];
  logic [31:0] drop_total_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
      drop_total_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && grant_cnt_q[i] != '1) grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
      end
      if (drop_hit && drop_total_q != '1) drop_total_q <= drop_total_q + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant_count
    assign grant_count[g*32 +: 32] = grant_cnt_q[g];
  end
  assign drop_count_total = drop_total_q;
`endif

`ifndef SYNTHESIS
  a_no_orphan_result: assert property (@(posedge clk) disable iff (rst)
    !(rc_valid_out && drop_cnt == '0 && fifo_empty));
  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rc_valid_in && fifo_full && !flush));
`endif

endmodule
`default_nettype wire

// File: tb/tb_raycast_arbiter.sv
`default_nettype none
// tb_raycast_arbiter: randomized requesters and raycaster against a queue-based reference of the arbiter.
module tb_raycast_arbiter;

  localparam int N   = 2;
  localparam int MAX = 4;
  localparam int VW  = 48;
  localparam int SW  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*VW-1:0]   req_src;
  logic [N*VW-1:0]   req_dir;
  logic [N-1:0]      resp_valid;
  logic              resp_hit;
  logic [VW-1:0]     resp_intersection;
  logic [VW-1:0]     resp_normal;
  logic [SW-1:0]     resp_shape;
  logic              rc_valid_in;
  logic [VW-1:0]     rc_src;
  logic [VW-1:0]     rc_dir;
  logic              rc_valid_out;
  logic              rc_hit;
  logic [VW-1:0]     rc_intersection;
  logic [VW-1:0]     rc_normal;
  logic [SW-1:0]     rc_hit_shape;
  logic [$clog2(MAX):0] inflight;
`ifdef RAYCAST_ARB_STATS_EN
  logic [N*32-1:0]   grant_count;
  logic [31:0]       drop_count_total;
`endif

  always #5 clk = ~clk;

  raycast_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAX)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_src           (req_src),
    .req_dir           (req_dir),
    .resp_valid        (resp_valid),
    .resp_hit          (resp_hit),
    .resp_intersection (resp_intersection),
    .resp_normal       (resp_normal),
    .resp_shape        (resp_shape),
    .rc_valid_in       (rc_valid_in),
    .rc_src            (rc_src),
    .rc_dir            (rc_dir),
    .rc_valid_out      (rc_valid_out),
    .rc_hit            (rc_hit),
    .rc_intersection   (rc_intersection),
    .rc_normal         (rc_normal),
    .rc_hit_shape      (rc_hit_shape),
`ifdef RAYCAST_ARB_STATS_EN
    .grant_count       (grant_count),
    .drop_count_total  (drop_count_total),
`endif
    .inflight          (inflight)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Requesters: each holds one pending ray until granted.
  bit          hold [N];
  logic [VW-1:0] psrc [N];
  logic [VW-1:0] pdir [N];

  // Raycaster model: in-order results with random latency.
  typedef struct {
    logic [VW-1:0] src;
    logic [VW-1:0] dir;
    int            due;
  } rc_ent_t;
  rc_ent_t rcq[$];
  int      last_due;

  // Reference: tags of live rays in issue order, results still owed to flushed rays.
  int            tag_q[$];
  int            drop;
  bit            pend_v;
  int            pend_tag;
  int            rr;
  logic [VW-1:0] exp_src, exp_dir;
  logic [N-1:0]  exp_resp_valid;
  logic          exp_hit;
  logic [VW-1:0] exp_int, exp_nrm;
  logic [SW-1:0] exp_shape;
  int            gcount [N];
  int            drops_total;

  task automatic model_reset();
    tag_q.delete();
    rcq.delete();
    last_due       = 0;
    drop           = 0;
    pend_v         = 0;
    pend_tag       = 0;
    rr             = 0;
    exp_src        = '0;
    exp_dir        = '0;
    exp_resp_valid = '0;
    exp_hit        = 1'b0;
    exp_int        = '0;
    exp_nrm        = '0;
    exp_shape      = '0;
    drops_total    = 0;
    for (int i = 0; i < N; i++) begin
      gcount[i] = 0;
      hold[i]   = 0;
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    flush        = 1'b0;
    req_valid    = '0;
    rc_valid_out = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run(input int cycles, input int req_pct, input int stall_pct, input int flush_pct);
    logic [63:0]  r64;
    logic [N-1:0] exp_ready;
    int           occ, gidx, idx, live, lat;
    rc_ent_t      e;
    for (int c = 0; c < cycles; c++) begin
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (!hold[i] && $urandom_range(99) < req_pct) begin
          hold[i] = 1;
          r64 = {$urandom(), $urandom()};
          psrc[i] = r64[VW-1:0];
          r64 = {$urandom(), $urandom()};
          pdir[i] = r64[VW-1:0];
        end
        req_valid[i] = hold[i];
        req_src[i*VW +: VW] = psrc[i];
        req_dir[i*VW +: VW] = pdir[i];
      end
      flush = ($urandom_range(99) < flush_pct);
      r64 = {$urandom(), $urandom()};
      rc_valid_out    = 1'b0;
      rc_hit          = r64[0];
      rc_intersection = r64[VW-1:0];
      rc_normal       = ~r64[VW-1:0];
      rc_hit_shape    = r64[SW-1:0];
      if (rcq.size() > 0 && rcq[0].due <= cyc && $urandom_range(99) >= stall_pct) begin
        e = rcq.pop_front();
        rc_valid_out    = 1'b1;
        rc_hit          = e.src[0] ^ e.dir[3];
        rc_intersection = e.src + e.dir;
        rc_normal       = e.dir ^ 48'h5a5a_a5a5_0f0f;
        rc_hit_shape    = e.src[7:0] ^ e.dir[15:8];
      end
      #1;
      occ  = tag_q.size() + drop + (pend_v ? 1 : 0);
      gidx = -1;
      if (!flush && occ < MAX) begin
        for (int k = 0; k < N; k++) begin
          idx = (rr + k) % N;
          if (gidx < 0 && hold[idx]) gidx = idx;
        end
      end
      exp_ready = '0;
      if (gidx >= 0) exp_ready[gidx] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("rc_valid_in", 64'(rc_valid_in), 64'(pend_v));
      check("rc_src", 64'(rc_src), 64'(exp_src));
      check("rc_dir", 64'(rc_dir), 64'(exp_dir));
      check("resp_valid", 64'(resp_valid), 64'(exp_resp_valid));
      check("resp_hit", 64'(resp_hit), 64'(exp_hit));
      check("resp_intersection", 64'(resp_intersection), 64'(exp_int));
      check("resp_normal", 64'(resp_normal), 64'(exp_nrm));
      check("resp_shape", 64'(resp_shape), 64'(exp_shape));
      check("inflight", 64'(inflight), 64'(tag_q.size()));
      if (pend_v) begin
        lat = int'($urandom_range(12, 1));
        last_due = (cyc + lat > last_due) ? cyc + lat : last_due;
        rcq.push_back('{src: exp_src, dir: exp_dir, due: last_due});
      end
      live = -1;
      if (rc_valid_out) begin
        if (drop > 0) begin
          drop--;
          drops_total++;
        end else begin
          live = tag_q.pop_front();
        end
      end
      if (pend_v) tag_q.push_back(pend_tag);
      if (flush) begin
        drop += tag_q.size();
        tag_q.delete();
      end
      exp_resp_valid = '0;
      if (live >= 0) begin
        exp_resp_valid[live] = 1'b1;
        exp_hit   = rc_hit;
        exp_int   = rc_intersection;
        exp_nrm   = rc_normal;
        exp_shape = rc_hit_shape;
      end
      pend_v = (gidx >= 0);
      if (gidx >= 0) begin
        pend_tag = gidx;
        exp_src  = psrc[gidx];
        exp_dir  = pdir[gidx];
        hold[gidx] = 0;
        rr = (gidx + 1) % N;
        gcount[gidx]++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst             = 1'b1;
    flush           = 1'b0;
    req_valid       = '0;
    req_src         = '0;
    req_dir         = '0;
    rc_valid_out    = 1'b0;
    rc_hit          = 1'b0;
    rc_intersection = '0;
    rc_normal       = '0;
    rc_hit_shape    = '0;
    @(negedge clk);
    do_reset();
    run(600, 60, 10, 2);
    run(600, 80, 88, 3);
    run(300, 30, 40, 8);
    do_reset();
    run(600, 70, 50, 4);
`ifdef RAYCAST_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("grant_count", 64'(grant_count[i*32 +: 32]), 64'(gcount[i]));
    check("drop_count_total", 64'(drop_count_total), 64'(drops_total));
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
